// File: rtl/cordic_pkg.sv
// cordic_pkg: FSM states, quadrant type and saturating negate shared by the CORDIC issue block.
package cordic_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;
  typedef logic [1:0] quad_t;
  // Operates on a sign-extended 64-bit word; w is the real word width, callers truncate back.
  function automatic logic signed [63:0] sat_neg(input logic signed [63:0] x, input int w);
    logic signed [63:0] lim;
    lim = 64'sd1 <<< (w - 1);
    return (x == -lim) ? lim - 64'sd1 : -x;
  endfunction
endpackage

// File: rtl/cordic_quad_fix.sv
// cordic_quad_fix: maps first-quadrant core results back to the requested quadrant.
module cordic_quad_fix
  import cordic_pkg::*;
#(
  parameter int BIT_WIDTH = 16
) (
  input  quad_t                       q,
  input  logic signed [BIT_WIDTH-1:0] c,
  input  logic signed [BIT_WIDTH-1:0] s,
  output logic signed [BIT_WIDTH-1:0] cos_o,
  output logic signed [BIT_WIDTH-1:0] sin_o
);
  logic signed [BIT_WIDTH-1:0] nc, ns;
  always_comb begin
    nc = BIT_WIDTH'(sat_neg(64'(c), BIT_WIDTH));
    ns = BIT_WIDTH'(sat_neg(64'(s), BIT_WIDTH));
    cos_o = (q == 2'd0) ? c : (q == 2'd1) ? ns : (q == 2'd2) ? nc : s;
    sin_o = (q == 2'd0) ? s : (q == 2'd1) ? c : (q == 2'd2) ? ns : nc;
  end
endmodule

// File: rtl/cordic_issue.sv
// cordic_issue: accepts a full-circle angle, issues a first-quadrant request to a CORDIC core,
// and returns quadrant-corrected results with a timeout error path.
module cordic_issue
  import cordic_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int MAX_WAIT  = BIT_WIDTH + 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [BIT_WIDTH-1:0]        in_angle,
  output logic                        core_start,
  output logic [BIT_WIDTH-1:0]        core_angle,
  input  logic                        core_done,
  input  logic signed [BIT_WIDTH-1:0] core_cos,
  input  logic signed [BIT_WIDTH-1:0] core_sin,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [BIT_WIDTH-1:0] out_cos,
  output logic signed [BIT_WIDTH-1:0] out_sin,
  output logic                        out_err
);
  localparam int CW = $clog2(MAX_WAIT);
  state_t                      state_q, state_d;
  quad_t                       quad_q, quad_d;
  logic [BIT_WIDTH-1:0]        angle_q, angle_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic signed [BIT_WIDTH-1:0] cos_q, cos_d, sin_q, sin_d, fix_cos, fix_sin;
  logic                        err_q, err_d;
  cordic_quad_fix #(.BIT_WIDTH(BIT_WIDTH)) u_fix (
    .q(quad_q), .c(core_cos), .s(core_sin), .cos_o(fix_cos), .sin_o(fix_sin)
  );
  always_comb begin
    state_d = state_q;
    quad_d  = quad_q;
    angle_d = angle_q;
    cnt_d   = cnt_q;
    cos_d   = cos_q;
    sin_d   = sin_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        state_d = S_ISSUE;
        quad_d  = in_angle[BIT_WIDTH-1 -: 2];
        angle_d = {2'b00, in_angle[BIT_WIDTH-3:0]};
      end
      S_ISSUE: if (core_done) begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: if (core_done) begin
        state_d = S_HOLD;
        cos_d   = fix_cos;
        sin_d   = fix_sin;
        err_d   = 1'b0;
      end else if (cnt_q == CW'(MAX_WAIT - 1)) begin
        state_d = S_HOLD;
        cos_d   = '0;
        sin_d   = '0;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      S_HOLD: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      quad_q  <= '0;
      angle_q <= '0;
      cnt_q   <= '0;
      cos_q   <= '0;
      sin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      quad_q  <= quad_d;
      angle_q <= angle_d;
      cnt_q   <= cnt_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
      err_q   <= err_d;
    end
  end
  assign in_ready   = state_q == S_IDLE;
  assign core_start = (state_q == S_ISSUE) && core_done;
  assign core_angle = angle_q;
  assign out_valid  = state_q == S_HOLD;
  assign out_cos    = cos_q;
  assign out_sin    = sin_q;
  assign out_err    = err_q;
endmodule

// File: tb/tb_cordic_issue.sv
// tb_cordic_issue: directed and randomized transactions checked against a quadrant-rotation model.
module tb_cordic_issue;
  localparam int BW = 16;
  localparam int MW = BW + 4;
  logic clk = 0, reset = 0, in_valid = 0, core_done = 1, out_ready = 0;
  logic in_ready, core_start, out_valid, out_err;
  logic [BW-1:0] in_angle = '0, core_angle;
  logic signed [BW-1:0] core_cos = '0, core_sin = '0, out_cos, out_sin;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  cordic_issue #(.BIT_WIDTH(BW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_angle(in_angle),
    .core_start(core_start), .core_angle(core_angle), .core_done(core_done),
    .core_cos(core_cos), .core_sin(core_sin), .out_valid(out_valid), .out_ready(out_ready),
    .out_cos(out_cos), .out_sin(out_sin), .out_err(out_err)
  );
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  function automatic int neg(input int x);
    return (x == -32768) ? 32767 : -x;
  endfunction
  function automatic void model(input logic [BW-1:0] a, input logic [BW-1:0] c,
                                input logic [BW-1:0] s, output logic [BW-1:0] ec,
                                output logic [BW-1:0] es);
    int ci, si, q;
    ci = int'(signed'(c));
    si = int'(signed'(s));
    q  = int'(a) / 16384;
    case (q)
      0: begin ec = 16'(ci); es = 16'(si); end
      1: begin ec = 16'(neg(si)); es = 16'(ci); end
      2: begin ec = 16'(neg(ci)); es = 16'(neg(si)); end
      default: begin ec = 16'(si); es = 16'(neg(ci)); end
    endcase
  endfunction
  task automatic txn(input logic [BW-1:0] a, input logic [BW-1:0] c, input logic [BW-1:0] s,
                     input int issue_stall, input int core_lat, input int hold_stall);
    logic [BW-1:0] ec, es;
    model(a, c, s, ec, es);
    chk("idle_ready", in_ready, 1);
    in_valid = 1; in_angle = a; out_ready = 0; core_done = 1;
    @(negedge clk);
    in_valid = 0; in_angle = 16'($urandom);
    chk("core_angle", core_angle, 16'(int'(a) % 16384));
    chk("busy_ready", in_ready, 0);
    repeat (issue_stall) begin
      core_done = 0; in_valid = 1'($urandom);
      #1 chk("stall_no_start", core_start, 0);
      chk("stall_ready", in_ready, 0);
      @(negedge clk);
    end
    in_valid = 0; core_done = 1;
    #1 chk("core_start", core_start, 1);
    @(negedge clk);
    for (int i = 1; i < core_lat; i++) begin
      core_done = 0; core_cos = 16'($urandom); core_sin = 16'($urandom); in_valid = 1'($urandom);
      #1 chk("wait_no_valid", out_valid, 0);
      chk("wait_no_start", core_start, 0);
      chk("angle_stable", core_angle, 16'(int'(a) % 16384));
      @(negedge clk);
    end
    in_valid = 0; core_done = 1; core_cos = c; core_sin = s;
    #1 chk("done_no_start", core_start, 0);
    @(negedge clk);
    core_cos = 16'($urandom); core_sin = 16'($urandom);
    chk("out_valid", out_valid, 1);
    chk("out_cos", out_cos, ec);
    chk("out_sin", out_sin, es);
    chk("out_err", out_err, 0);
    chk("hold_ready", in_ready, 0);
    repeat (hold_stall) begin
      in_valid = 1'($urandom); in_angle = 16'($urandom);
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_cos", out_cos, ec);
      chk("hold_sin", out_sin, es);
      chk("hold_ready", in_ready, 0);
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("released", out_valid, 0);
    chk("back_ready", in_ready, 1);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_start", core_start, 0);
    chk("rst_angle", core_angle, 0);
    chk("rst_err", out_err, 0);
    chk("rst_cos", out_cos, 0);
    reset = 1;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1);
    txn(16'h1234, 16'h7000, 16'h2000, 0, 3, 0);
    txn(16'h4000, 16'h7FFF, 16'h0000, 0, 2, 1);
    txn(16'h8100, 16'h8000, 16'h0100, 0, 1, 0);
    txn(16'hC123, 16'h8000, 16'h1234, 3, 4, 5);
    for (int n = 0; n < 40; n++) begin
      logic [BW-1:0] c, s;
      c = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
      s = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
      txn(16'($urandom), c, s, $urandom_range(0, 3), $urandom_range(1, 6), $urandom_range(0, 3));
    end
    in_valid = 1; in_angle = 16'h5555; core_done = 1;
    @(negedge clk);
    in_valid = 0;
    #1 chk("to_start", core_start, 1);
    @(negedge clk);
    core_done = 0;
    repeat (MW) begin
      #1 chk("to_no_valid", out_valid, 0);
      @(negedge clk);
    end
    chk("to_valid", out_valid, 1);
    chk("to_cos", out_cos, 0);
    chk("to_sin", out_sin, 0);
    chk("to_err", out_err, 1);
    out_ready = 1; core_done = 1;
    @(negedge clk);
    out_ready = 0;
    chk("to_ready", in_ready, 1);
    txn(16'h6789, 16'h1111, 16'h2222, 1, 2, 0);
    in_valid = 1; in_angle = 16'hABCD; core_done = 1;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    core_done = 0;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    reset = 1; core_done = 1;
    #1 chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_start", core_start, 0);
    chk("mid_rst_angle", core_angle, 0);
    chk("mid_rst_cos", out_cos, 0);
    chk("mid_rst_sin", out_sin, 0);
    chk("mid_rst_err", out_err, 0);
    chk("mid_rst_ready", in_ready, 1);
    repeat (MW + 4) begin
      @(negedge clk);
      chk("abandoned_no_valid", out_valid, 0);
    end
    txn(16'hE000, 16'h0100, 16'h8000, 0, 2, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
